// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, FIFO entry layout
// and the feeder FSM state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_CSUM,
    ST_SEND_C
  } feeder_state_e;

  typedef struct packed {
    logic                   last;
    logic [UART_BYTE_W-1:0] data;
  } fifo_entry_t;

  localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO holding {last,data} entries between the frame source and the
// feeder FSM. Push when full and pop when empty are ignored.
module uart_byte_fifo #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [ADDR_W:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_feeder.sv
// Buffers frame bytes and paces them into a UART transmitter over data/send/busy.
// Define UART_FEEDER_CHECKSUM_EN to append an XOR checksum byte after every frame.
module uart_tx_frame_feeder
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [UART_BYTE_W-1:0] in_data_i,
  input  logic                   in_valid_i,
  input  logic                   in_last_i,
  output logic                   in_ready_o,
  output logic [UART_BYTE_W-1:0] uart_data_o,
  output logic                   uart_send_o,
  input  logic                   uart_busy_i,
  output logic [ADDR_W:0]        fifo_count_o,
  output logic                   frame_done_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  feeder_state_e          state_q;
  logic [UART_BYTE_W-1:0] uart_data_q;
  logic                   uart_send_q;
  logic                   frame_done_q;
  logic                   last_q;
  logic                   in_ready_q;
`ifdef UART_FEEDER_CHECKSUM_EN
  logic [UART_BYTE_W-1:0] acc_q;
  logic                   csum_phase_q;
`endif

  fifo_entry_t     wr_entry;
  fifo_entry_t     head;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic [ADDR_W:0] fifo_count_d;

  assign wr_entry = '{last: in_last_i, data: in_data_i};
  assign push     = in_valid_i && in_ready_q && !fifo_full;
  assign pop      = (state_q == ST_IDLE) && !fifo_empty && !uart_busy_i;

  uart_byte_fifo #(
    .WIDTH (FIFO_ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .wdata_i(wr_entry),
    .pop_i  (pop),
    .rdata_o(head),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    fifo_count_d = fifo_count;
    if (push && !pop) begin
      fifo_count_d = fifo_count + CNT_ONE;
    end else if (pop && !push) begin
      fifo_count_d = fifo_count - CNT_ONE;
    end
  end

  // Ready is registered from the next occupancy so it always equals count < depth
  // once out of reset, without a combinational path from the FIFO count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (fifo_count_d < DEPTH_C);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      uart_data_q  <= '0;
      uart_send_q  <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
`ifdef UART_FEEDER_CHECKSUM_EN
      acc_q        <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      uart_send_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            uart_data_q <= head.data;
            last_q      <= head.last;
            uart_send_q <= 1'b1;
            state_q     <= ST_SEND;
`ifdef UART_FEEDER_CHECKSUM_EN
            acc_q       <= acc_q ^ head.data;
`endif
          end
        end
        ST_SEND: begin
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (uart_busy_i) begin
            state_q <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!uart_busy_i) begin
`ifdef UART_FEEDER_CHECKSUM_EN
            if (csum_phase_q) begin
              frame_done_q <= 1'b1;
              acc_q        <= '0;
              csum_phase_q <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (last_q) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_IDLE;
            end
`else
            if (last_q) begin
              frame_done_q <= 1'b1;
            end
            state_q <= ST_IDLE;
`endif
          end
        end
`ifdef UART_FEEDER_CHECKSUM_EN
        ST_CSUM: begin
          uart_data_q <= acc_q;
          uart_send_q <= 1'b1;
          state_q     <= ST_SEND_C;
        end
        ST_SEND_C: begin
          csum_phase_q <= 1'b1;
          state_q      <= ST_WAIT_HI;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign uart_data_o  = uart_data_q;
  assign uart_send_o  = uart_send_q;
  assign frame_done_o = frame_done_q;
  assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_uart_tx_frame_feeder.sv
// Directed bench for uart_tx_frame_feeder paired with a behavioural UART transmitter
// (16 clocks per bit) and a line decoder; honours UART_FEEDER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_tx_frame_feeder;

  typedef logic [7:0] byteQ_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inData = 8'h00;
  logic       inValid = 1'b0;
  logic       inLast = 1'b0;
  logic       inReady;
  logic [7:0] uartData;
  logic       uartSend;
  logic       uartBusy;
  logic [4:0] fifoCount;
  logic       frameDone;

  int checks = 0;
  int errors = 0;

  // Behavioural transmitter state
  logic       txBusy = 1'b0;
  logic [9:0] txShift = 10'h3FF;
  logic [3:0] txTick = 4'd0;
  logic [3:0] txBit = 4'd0;
  logic [7:0] txData = 8'h00;
  logic       txCheck = 1'b0;
  logic       txLine;

  int sendCount = 0;
  int doneCount = 0;
  int sendWhileBusy = 0;
  int doneWhileBusy = 0;
  int dataUnstable = 0;
  int rxFrameErr = 0;
  int readyBad = 0;
  int maxCount = 0;
  bit monEn = 1'b0;

  byteQ_t sentQ;
  byteQ_t rxQ;

  always #5 clk = ~clk;

  assign uartBusy = txBusy;
  assign txLine   = txBusy ? txShift[0] : 1'b1;

  uart_tx_frame_feeder #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (inData),
    .in_valid_i  (inValid),
    .in_last_i   (inLast),
    .in_ready_o  (inReady),
    .uart_data_o (uartData),
    .uart_send_o (uartSend),
    .uart_busy_i (uartBusy),
    .fifo_count_o(fifoCount),
    .frame_done_o(frameDone)
  );

  // Transmitter: busy rises the cycle after send, 10 bits of 16 clocks each.
  always @(posedge clk) begin
    if (uartSend && txBusy) sendWhileBusy <= sendWhileBusy + 1;
    if (!txBusy) begin
      if (uartSend) begin
        txBusy  <= 1'b1;
        txShift <= {1'b1, uartData, 1'b0};
        txTick  <= 4'd0;
        txBit   <= 4'd0;
        txData  <= uartData;
        txCheck <= 1'b1;
      end
    end else begin
      if (!rst_n) txCheck <= 1'b0;
      else if (txCheck && (uartData !== txData)) dataUnstable <= dataUnstable + 1;
      if (txTick == 4'd15) begin
        txTick <= 4'd0;
        if (txBit == 4'd9) begin
          txBusy <= 1'b0;
        end else begin
          txBit   <= txBit + 4'd1;
          txShift <= {1'b1, txShift[9:1]};
        end
      end else begin
        txTick <= txTick + 4'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (uartSend) begin
      sendCount <= sendCount + 1;
      sentQ.push_back(uartData);
    end
    if (frameDone) begin
      doneCount <= doneCount + 1;
      if (uartBusy) doneWhileBusy <= doneWhileBusy + 1;
    end
  end

  always @(negedge clk) begin
    if (monEn) begin
      if (int'(fifoCount) > maxCount) maxCount <= int'(fifoCount);
      if (inReady !== (fifoCount < 5'd16) || fifoCount > 5'd16) readyBad <= readyBad + 1;
    end
  end

  // Line decoder: samples mid-bit, LSB first
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (txLine == 1'b0) begin
        repeat (8) @(posedge clk);
        if (txLine !== 1'b0) rxFrameErr++;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge clk);
          b[i] = txLine;
        end
        repeat (16) @(posedge clk);
        if (txLine !== 1'b1) rxFrameErr++;
        rxQ.push_back(b);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit sameBytes(input byteQ_t a, input byteQ_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmtBytes(input byteQ_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] d, input logic last);
    bit ok = 1'b0;
    bit wasReady;
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    for (int c = 0; c < 3000 && !ok; c++) begin
      wasReady = inReady;
      stepCycle();
      if (wasReady) ok = 1'b1;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: byte %h not accepted, required acceptance within 3000 cycles", d);
    end
  endtask

  task automatic waitQuiet(input int maxCycles, input string tag);
    int quiet = 0;
    int c = 0;
    while (quiet < 40 && c < maxCycles) begin
      stepCycle();
      c++;
      if (!uartBusy && fifoCount == 5'd0 && !uartSend) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 40) begin
      errors++;
      $display("[TB] FAIL %s_drain: still active after %0d cycles, required idle", tag, maxCycles);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    inValid = 1'b1;
    inData  = 8'hFF;
    inLast  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checks++;
      if ({uartSend, inReady, fifoCount, uartData, frameDone} !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_outputs: send=%b ready=%b count=%0d data=%h done=%b, required all zero",
                 uartSend, inReady, fifoCount, uartData, frameDone);
      end
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    rst_n   = 1'b1;
    stepCycle();
    stepCycle();
    checks++;
    if (inReady !== 1'b1 || fifoCount !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%b count=%0d, required ready=1 count=0", inReady, fifoCount);
    end
  endtask

  task automatic test_single_byte();
    byteQ_t exp;
    int doneBase = doneCount;
    sentQ.delete();
    rxQ.delete();
    exp = '{8'h5A};
`ifdef UART_FEEDER_CHECKSUM_EN
    exp.push_back(8'h5A);
`endif
    inValid = 1'b1;
    inData  = 8'h5A;
    inLast  = 1'b1;
    stepCycle();
    inValid = 1'b0;
    inLast  = 1'b0;
    checks++;
    if (fifoCount !== 5'd1 || uartSend !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle_cycle: count=%0d send=%b, required count=1 send=0", fifoCount, uartSend);
    end
    stepCycle();
    checks++;
    if (uartSend !== 1'b1 || uartData !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL single_launch: send=%b data=%h, required send=1 data=5a", uartSend, uartData);
    end
    checks++;
    if (fifoCount !== 5'd0) begin
      errors++;
      $display("[TB] FAIL single_popped: count=%0d, required 0", fifoCount);
    end
    stepCycle();
    checks++;
    if (uartSend !== 1'b0 || uartBusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_pulse_width: send=%b busy=%b, required send=0 busy=1", uartSend, uartBusy);
    end
    waitQuiet(1000, "single");
    checks++;
    if (!sameBytes(rxQ, exp) || rxFrameErr != 0) begin
      errors++;
      $display("[TB] FAIL single_serial: line bytes %s framing errors %0d, required %s with 0 errors",
               fmtBytes(rxQ), rxFrameErr, fmtBytes(exp));
    end
    checks++;
    if (doneCount - doneBase != 1 || doneWhileBusy != 0) begin
      errors++;
      $display("[TB] FAIL single_frame_done: %0d pulses (%0d while busy), required 1 (0 while busy)",
               doneCount - doneBase, doneWhileBusy);
    end
  endtask

  task automatic test_burst();
    byteQ_t exp;
    int doneBase = doneCount;
    sentQ.delete();
    rxQ.delete();
    maxCount = 0;
    readyBad = 0;
    monEn    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pushByte(8'(i), i == 19);
      exp.push_back(8'(i));
    end
`ifdef UART_FEEDER_CHECKSUM_EN
    exp.push_back(8'h00);
`endif
    waitQuiet(6000, "burst");
    monEn = 1'b0;
    checks++;
    if (maxCount != 16) begin
      errors++;
      $display("[TB] FAIL burst_peak_count: peak %0d, required 16", maxCount);
    end
    checks++;
    if (readyBad != 0) begin
      errors++;
      $display("[TB] FAIL burst_ready_rule: %0d cycles with ready != (count<16), required 0", readyBad);
    end
    checks++;
    if (!sameBytes(sentQ, exp)) begin
      errors++;
      $display("[TB] FAIL burst_sent: %s, required %s", fmtBytes(sentQ), fmtBytes(exp));
    end
    checks++;
    if (!sameBytes(rxQ, exp) || rxFrameErr != 0) begin
      errors++;
      $display("[TB] FAIL burst_serial: %s (framing %0d), required %s", fmtBytes(rxQ), rxFrameErr, fmtBytes(exp));
    end
    checks++;
    if (doneCount - doneBase != 1 || dataUnstable != 0 || sendWhileBusy != 0) begin
      errors++;
      $display("[TB] FAIL burst_handshake: done=%0d unstable=%0d sendWhileBusy=%0d, required 1 0 0",
               doneCount - doneBase, dataUnstable, sendWhileBusy);
    end
  endtask

  task automatic test_full_push_pop();
    byteQ_t exp;
    sentQ.delete();
    rxQ.delete();
    maxCount = 0;
    readyBad = 0;
    monEn    = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      pushByte(8'h80 + 8'(i), 1'b0);
      exp.push_back(8'h80 + 8'(i));
    end
    checks++;
    if (fifoCount !== 5'd16 || inReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_reached: count=%0d ready=%b, required count=16 ready=0", fifoCount, inReady);
    end
    for (int i = 17; i < 20; i++) begin
      pushByte(8'h80 + 8'(i), i == 19);
      exp.push_back(8'h80 + 8'(i));
      checks++;
      if (fifoCount !== 5'd16 || inReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL full_push_pop_%0d: count=%0d ready=%b, required count=16 ready=0", i, fifoCount, inReady);
      end
    end
`ifdef UART_FEEDER_CHECKSUM_EN
    exp.push_back(8'h00);
`endif
    waitQuiet(6000, "full");
    monEn = 1'b0;
    checks++;
    if (maxCount != 16 || readyBad != 0) begin
      errors++;
      $display("[TB] FAIL full_bound: peak %0d bad-ready %0d, required 16 and 0", maxCount, readyBad);
    end
    checks++;
    if (!sameBytes(rxQ, exp)) begin
      errors++;
      $display("[TB] FAIL full_order: %s, required %s", fmtBytes(rxQ), fmtBytes(exp));
    end
  endtask

  task automatic test_frames();
    byteQ_t exp;
    int doneBase = doneCount;
    sentQ.delete();
    rxQ.delete();
    pushByte(8'h01, 1'b0);
    pushByte(8'h02, 1'b0);
    pushByte(8'h04, 1'b1);
    pushByte(8'h10, 1'b0);
    pushByte(8'h20, 1'b1);
`ifdef UART_FEEDER_CHECKSUM_EN
    exp = '{8'h01, 8'h02, 8'h04, 8'h07, 8'h10, 8'h20, 8'h30};
`else
    exp = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h20};
`endif
    waitQuiet(3000, "frames");
    checks++;
    if (!sameBytes(rxQ, exp) || rxFrameErr != 0) begin
      errors++;
      $display("[TB] FAIL frames_serial: %s (framing %0d), required %s", fmtBytes(rxQ), rxFrameErr, fmtBytes(exp));
    end
`ifdef UART_FEEDER_CHECKSUM_EN
    checks++;
    if (sentQ.size() < 4 || sentQ[3] !== 8'h07) begin
      errors++;
      $display("[TB] FAIL frames_checksum: sent %s, required fourth byte 07", fmtBytes(sentQ));
    end
`endif
    checks++;
    if (doneCount - doneBase != 2 || doneWhileBusy != 0) begin
      errors++;
      $display("[TB] FAIL frames_done: %0d pulses (%0d while busy), required 2 (0 while busy)",
               doneCount - doneBase, doneWhileBusy);
    end
  endtask

  task automatic test_reset_mid_byte();
    byteQ_t exp;
    int doneBase = doneCount;
    int sendBase = sendCount;
    int c = 0;
    sentQ.delete();
    rxQ.delete();
    pushByte(8'hA1, 1'b0);
    pushByte(8'hA2, 1'b0);
    pushByte(8'hA3, 1'b0);
    pushByte(8'hA4, 1'b1);
    while (sendCount - sendBase < 2 && c < 1000) begin
      stepCycle();
      c++;
    end
    checks++;
    if (sendCount - sendBase < 2) begin
      errors++;
      $display("[TB] FAIL midreset_second_send: %0d sends, required 2 within 1000 cycles", sendCount - sendBase);
    end
    repeat (40) stepCycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifoCount, uartSend, inReady, uartData, frameDone} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: count=%0d send=%b ready=%b data=%h done=%b, required all zero",
               fifoCount, uartSend, inReady, uartData, frameDone);
    end
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    pushByte(8'h5C, 1'b1);
    exp = '{8'hA1, 8'hA2, 8'h5C};
`ifdef UART_FEEDER_CHECKSUM_EN
    exp.push_back(8'h5C);
`endif
    waitQuiet(2000, "midreset");
    checks++;
    if (sendWhileBusy != 0) begin
      errors++;
      $display("[TB] FAIL midreset_retrigger: %0d sends while busy, required 0", sendWhileBusy);
    end
    checks++;
    if (!sameBytes(rxQ, exp) || !sameBytes(sentQ, exp)) begin
      errors++;
      $display("[TB] FAIL midreset_bytes: line %s sent %s, required %s", fmtBytes(rxQ), fmtBytes(sentQ), fmtBytes(exp));
    end
    checks++;
    if (doneCount - doneBase != 1) begin
      errors++;
      $display("[TB] FAIL midreset_done: %0d pulses, required 1", doneCount - doneBase);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_full_push_pop();
    test_frames();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
